wos_weight_expander: RTL and testbench

Upstream feeder for the rank-order filter core. It accepts samples paired with an integer weight through a valid/ready handshake and emits each sample that many times, one copy per cycle, as a shift-enabled stream. Replication gives the downstream rank-order window its weighted-order-statistics semantics. It also tracks window fill, so consumers ignore the filter output until N samples have entered the window.

---
 rtl/wos_weight_expander.sv | 98 +++++++++
 tb/tb_wos_weight_expander.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/wos_weight_expander.sv
// Weighted-sample expander feeding the rank-order filter core: each accepted
// sample is replayed once per cycle for in_weight cycles, and window fill is tracked.
module wos_weight_expander #(
  parameter int N           = 5,
  parameter int DATA_BITS   = 8,
  parameter int WEIGHT_BITS = 3,
  parameter int FILL_BITS   = $clog2(N + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_BITS-1:0]   in_data,
  input  logic [WEIGHT_BITS-1:0] in_weight,
  output logic                   out_valid,
  output logic [DATA_BITS-1:0]   out_data,
  output logic                   window_full,
  output logic                   debug_state
);

  // Handshake: a sample transfers on a rising edge where in_valid and in_ready
  // are both high. in_ready is derived from registered state and flush only,
  // never from in_valid; in_valid may be withdrawn before a transfer.

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t                 state, state_next;
  logic [WEIGHT_BITS-1:0] remaining, remaining_next;
  logic [DATA_BITS-1:0]   hold, hold_next;
  logic [FILL_BITS-1:0]   fill, fill_next;
  logic                   started;
  logic                   last_copy;
  logic                   accept;

  // started keeps in_ready low until the first edge after reset release.
  assign last_copy = (state == EMIT) && (remaining == WEIGHT_BITS'(1));
  assign in_ready  = started && !flush && ((state == IDLE) || last_copy);
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_next     = state;
    remaining_next = remaining;
    hold_next      = hold;
    fill_next      = fill;

    if (flush) begin
      state_next     = IDLE;
      remaining_next = '0;
      fill_next      = '0;
    end else begin
      if (state == EMIT) begin
        if (last_copy) begin
          state_next     = IDLE;
          remaining_next = '0;
        end else begin
          remaining_next = remaining - WEIGHT_BITS'(1);
        end
      end
      // A weight-0 sample is consumed but never reaches the output.
      if (accept && (in_weight != '0)) begin
        state_next     = EMIT;
        remaining_next = in_weight;
        hold_next      = in_data;
      end
      // Count the copy that becomes visible after this edge; saturate at N.
      if ((state_next == EMIT) && (fill != FILL_BITS'(N))) begin
        fill_next = fill + FILL_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      remaining   <= '0;
      hold        <= '0;
      fill        <= '0;
      window_full <= 1'b0;
      started     <= 1'b0;
    end else begin
      state       <= state_next;
      remaining   <= remaining_next;
      hold        <= hold_next;
      fill        <= fill_next;
      window_full <= (fill_next == FILL_BITS'(N));
      started     <= 1'b1;
    end
  end

  assign out_valid   = (state == EMIT);
  assign out_data    = hold;
  assign debug_state = state;

endmodule

// File: tb/tb_wos_weight_expander.sv
// Bench for wos_weight_expander: directed test-plan steps followed by random
// traffic, all compared each cycle against a queue-of-copies reference model.
module tb_wos_weight_expander;

  localparam int N  = 5;
  localparam int DB = 8;
  localparam int WB = 3;

  logic          clk       = 1'b0;
  logic          rst       = 1'b0;
  logic          flush     = 1'b0;
  logic          in_valid  = 1'b0;
  logic [DB-1:0] in_data   = '0;
  logic [WB-1:0] in_weight = '0;
  logic          in_ready;
  logic          out_valid;
  logic [DB-1:0] out_data;
  logic          window_full;
  logic          debug_state;

  wos_weight_expander #(.N(N), .DATA_BITS(DB), .WEIGHT_BITS(WB)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_weight   (in_weight),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .window_full (window_full),
    .debug_state (debug_state)
  );

  always #5 clk = ~clk;

  // Reference model: exp_q holds every copy still to be shown, head = current output.
  logic [DB-1:0] exp_q[$];
  int            fill_m      = 0;
  logic [DB-1:0] last_m      = '0;
  bit            started_m   = 1'b0;
  bit            last_accept = 1'b0;
  int            compared    = 0;
  int            mismatched  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    fill_m    = 0;
    last_m    = '0;
    started_m = 1'b0;
  endtask

  task automatic cycle();
    logic exp_ready;
    @(negedge clk);
    exp_ready = started_m && !flush && (exp_q.size() <= 1);
    check("in_ready", in_ready, exp_ready);
    check("out_valid", out_valid, exp_q.size() > 0);
    check("out_data", out_data, last_m);
    check("window_full", window_full, fill_m == N);
    last_accept = in_valid && exp_ready;
    @(posedge clk);
    if (flush) begin
      exp_q.delete();
      fill_m = 0;
    end else begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      if (last_accept)
        for (int i = 0; i < int'(in_weight); i++) exp_q.push_back(in_data);
      if (exp_q.size() > 0) begin
        last_m = exp_q[0];
        if (fill_m < N) fill_m++;
      end
    end
    started_m = 1'b1;
    #1;
  endtask

  // Present a sample and hold it until it is taken (bounded).
  task automatic send(input logic [DB-1:0] d, input logic [WB-1:0] w);
    bit got;
    got       = 1'b0;
    in_valid  = 1'b1;
    in_data   = d;
    in_weight = w;
    for (int k = 0; k < 20 && !got; k++) begin
      cycle();
      got = last_accept;
    end
    check("send_accept", got, 1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int k = 0; k < n; k++) cycle();
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_window_full", window_full, 0);
    @(posedge clk);
    #2 rst = 1'b1;

    // Back-to-back weight-1 stream
    send(8'd10, 3'd1);
    send(8'd20, 3'd1);
    send(8'd30, 3'd1);
    send(8'd40, 3'd1);
    send(8'd50, 3'd1);
    check("full_at_50", window_full, 1);
    send(8'd60, 3'd1);
    idle(2);

    // Weight 3 then weight 2 held, no gap
    send(8'd7, 3'd3);
    send(8'd9, 3'd2);
    idle(3);

    // Weight 0 is dropped
    send(8'd5, 3'd0);
    send(8'd6, 3'd2);
    idle(3);

    // Flush on third copy of a weight-7 sample
    send(8'd3, 3'd7);
    in_valid = 1'b0;
    cycle();
    cycle();
    flush = 1'b1;
    in_valid = 1'b1;
    in_data = 8'd99;
    in_weight = 3'd1;
    cycle();
    flush = 1'b0;
    check("flush_not_taken", last_accept, 0);
    send(8'd11, 3'd1);
    send(8'd12, 3'd1);
    send(8'd13, 3'd1);
    send(8'd14, 3'd1);
    idle(2);
    check("flush_no_full", window_full, 0);

    // Gaps between weight-1 samples
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    send(8'd1, 3'd1);
    idle(3);
    send(8'd2, 3'd1);
    idle(2);

    // Asynchronous reset mid-emission
    send(8'd8, 3'd5);
    in_valid = 1'b0;
    cycle();
    cycle();
    #2 rst = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_out_data", out_data, 0);
    check("arst_window_full", window_full, 0);
    check("arst_in_ready", in_ready, 0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    idle(6);

    // Random traffic including weight 0, max weight and flush
    for (int c = 0; c < 600; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_data   = DB'($urandom);
      in_weight = WB'($urandom_range(0, 7));
      flush     = ($urandom_range(0, 29) == 0);
      cycle();
    end
    flush = 1'b0;
    idle(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
